write_arbiter: RTL and testbench

- Write-path arbiter for the AXI crossbar.
- Decodes each master's AWADDR, arbitrates per slave with round-robin among requesting masters, and holds each grant for the whole transaction: AW, then W burst, then B.
- Drives the SWIdx/MWIdx select vectors consumed by the crossbar's write-channel multiplexer.
- Index NUM_M denotes the dummy master (all inputs tied 0); index NUM_S+1 denotes the dummy slave (all inputs tied 0).

---
 rtl/write_arbiter.sv | 173 +++++++++++++++++
 tb/tb_write_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/write_arbiter.sv
// Write-path arbiter for the AXI crossbar: per-slave round-robin grant held for AW, W burst and B.
// Optional B-wait timeout is compiled in with `define WARB_TIMEOUT_EN.
module write_arbiter #(
  parameter int NUM_M       = 3,
  parameter int NUM_S       = 6,
  parameter int MIDX_BITS   = 3,
  parameter int SIDX_BITS   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                ACLK,
  input  logic                                ARESET,
  input  logic [NUM_M-1:0][31:0]              AWADDR_M,
  input  logic [NUM_M-1:0]                    AWVALID_M,
  input  logic [NUM_S:0]                      AWREADY_S,
  input  logic [NUM_M-1:0]                    WVALID_M,
  input  logic [NUM_M-1:0]                    WLAST_M,
  input  logic [NUM_S:0]                      WREADY_S,
  input  logic [NUM_S:0]                      BVALID_S,
  input  logic [NUM_M-1:0]                    BREADY_M,
  output logic [NUM_S:0][SIDX_BITS-1:0]       SWIdx,
  output logic [NUM_M-1:0][MIDX_BITS-1:0]     MWIdx,
  output logic [NUM_S:0]                      WTimeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_DATA, ST_RESP} state_t;

  function automatic logic [MIDX_BITS-1:0] decode(input logic [31:0] addr);
    logic [MIDX_BITS-1:0] idx;
    idx = MIDX_BITS'(NUM_S);
    if (addr <= 32'h0000_3FFF)                                idx = MIDX_BITS'(0);
    else if (addr >= 32'h0001_0000 && addr <= 32'h0001_FFFF) idx = MIDX_BITS'(1);
    else if (addr >= 32'h0002_0000 && addr <= 32'h0002_FFFF) idx = MIDX_BITS'(2);
    else if (addr >= 32'h1002_0000 && addr <= 32'h1002_0400) idx = MIDX_BITS'(3);
    else if (addr >= 32'h1001_0000 && addr <= 32'h1001_03FF) idx = MIDX_BITS'(4);
    else if (addr >= 32'h2000_0000 && addr <= 32'h201F_FFFF) idx = MIDX_BITS'(5);
    return idx;
  endfunction

  logic [NUM_M-1:0][MIDX_BITS-1:0] dec;
  logic [NUM_M-1:0]                busy;
  logic [NUM_S:0]                  active;
  logic [NUM_S:0][SIDX_BITS-1:0]   owner_s;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_dec
      assign dec[gi] = decode(AWADDR_M[gi]);
    end
  endgenerate

  // A master already holding any slave may not be granted a second one.
  always_comb begin
    busy = '0;
    for (int m = 0; m < NUM_M; m++) begin
      MWIdx[m] = MIDX_BITS'(NUM_S + 1);
      for (int s = 0; s <= NUM_S; s++) begin
        if (active[s] && owner_s[s] == SIDX_BITS'(m)) begin
          busy[m]  = 1'b1;
          MWIdx[m] = MIDX_BITS'(s);
        end
      end
    end
  end

`ifndef WARB_TIMEOUT_EN
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  generate
    for (gi = 0; gi <= NUM_S; gi++) begin : g_slave
      state_t               state_reg, state_next;
      logic [SIDX_BITS-1:0] owner_reg, owner_next;
      logic [SIDX_BITS-1:0] ptr_reg, ptr_next;
      logic [NUM_M-1:0]     elig;
      logic                 grant_found;
      logic [SIDX_BITS-1:0] grant_idx;
      logic [SIDX_BITS-1:0] cand;
      logic                 timeout_next;

      always_comb begin
        for (int m = 0; m < NUM_M; m++)
          elig[m] = AWVALID_M[m] && (dec[m] == MIDX_BITS'(gi)) && !busy[m];
      end

      always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_M; i++) begin
          cand = SIDX_BITS'((int'(ptr_reg) + i) % NUM_M);
          if (!grant_found && elig[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
          end
        end
      end

`ifdef WARB_TIMEOUT_EN
      localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
      logic [CNT_W-1:0] cnt_reg;
      logic             timeout_reg;

      // Counter is held at zero outside RESP, so it starts from zero on entry.
      always_ff @(posedge ACLK) begin
        if (ARESET) begin
          cnt_reg     <= '0;
          timeout_reg <= 1'b0;
        end else begin
          cnt_reg     <= (state_reg == ST_RESP) ? cnt_reg + 1'b1 : '0;
          timeout_reg <= timeout_next;
        end
      end
      assign WTimeout[gi] = timeout_reg;
`else
      assign WTimeout[gi] = 1'b0;
`endif

      always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        ptr_next     = ptr_reg;
        timeout_next = 1'b0;
        case (state_reg)
          ST_IDLE: begin
            if (grant_found) begin
              owner_next = grant_idx;
              state_next = ST_AW;
            end
          end
          ST_AW: begin
            if (AWVALID_M[owner_reg] && AWREADY_S[gi]) begin
              ptr_next   = (owner_reg == SIDX_BITS'(NUM_M - 1)) ? '0 : owner_reg + 1'b1;
              state_next = ST_DATA;
            end
          end
          ST_DATA: begin
            if (WVALID_M[owner_reg] && WREADY_S[gi] && WLAST_M[owner_reg])
              state_next = ST_RESP;
          end
          ST_RESP: begin
            if (BVALID_S[gi] && BREADY_M[owner_reg])
              state_next = ST_IDLE;
`ifdef WARB_TIMEOUT_EN
            else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
              state_next   = ST_IDLE;
              timeout_next = 1'b1;
            end
`endif
          end
          default: state_next = ST_IDLE;
        endcase
      end

      always_ff @(posedge ACLK) begin
        if (ARESET) begin
          state_reg <= ST_IDLE;
          owner_reg <= '0;
          ptr_reg   <= '0;
        end else begin
          state_reg <= state_next;
          owner_reg <= owner_next;
          ptr_reg   <= ptr_next;
        end
      end

      assign active[gi]  = (state_reg != ST_IDLE);
      assign owner_s[gi] = owner_reg;
      assign SWIdx[gi]   = active[gi] ? owner_reg : SIDX_BITS'(NUM_M);
    end
  endgenerate

endmodule

// File: tb/tb_write_arbiter.sv
// Directed table-driven bench for write_arbiter, plus hand-written abort and B-wait timeout sequences.
module tb_write_arbiter;

  logic                 ACLK = 1'b0;
  logic                 ARESET;
  logic [2:0][31:0]     AWADDR_M;
  logic [2:0]           AWVALID_M, WVALID_M, WLAST_M, BREADY_M;
  logic [6:0]           AWREADY_S, WREADY_S, BVALID_S;
  logic [6:0][1:0]      SWIdx;
  logic [2:0][2:0]      MWIdx;
  logic [6:0]           WTimeout;

  write_arbiter #(
    .NUM_M(3), .NUM_S(6), .MIDX_BITS(3), .SIDX_BITS(2), .TIMEOUT_CYC(8)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .AWADDR_M(AWADDR_M), .AWVALID_M(AWVALID_M),
    .AWREADY_S(AWREADY_S), .WVALID_M(WVALID_M), .WLAST_M(WLAST_M), .WREADY_S(WREADY_S),
    .BVALID_S(BVALID_S), .BREADY_M(BREADY_M), .SWIdx(SWIdx), .MWIdx(MWIdx), .WTimeout(WTimeout)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    string           name;
    logic            rst;
    logic [2:0][31:0] addr;
    logic [2:0]      awv;
    logic [6:0]      awr;
    logic [2:0]      wv;
    logic [2:0]      wl;
    logic [6:0]      bv;
    logic [6:0][1:0] sw;
    logic [2:0][2:0] mw;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [6:0][1:0] SW_IDLE = '1;
  localparam logic [2:0][2:0] MW_IDLE = '1;
  localparam logic [6:0]      RDY     = 7'h7F;

  function automatic logic [6:0][1:0] swx(input int s0, input int m0, input int s1 = -1, input int m1 = 0);
    logic [6:0][1:0] r;
    r = '1;
    r[s0] = 2'(m0);
    if (s1 >= 0) r[s1] = 2'(m1);
    return r;
  endfunction

  function automatic logic [2:0][2:0] mwx(input int m0, input int s0, input int m1 = -1, input int s1 = 0);
    logic [2:0][2:0] r;
    r = '1;
    r[m0] = 3'(s0);
    if (m1 >= 0) r[m1] = 3'(s1);
    return r;
  endfunction

  function automatic void add(input string nm, input logic rst, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [2:0] awv, input logic [6:0] awr,
                              input logic [2:0] wv, input logic [2:0] wl, input logic [6:0] bv,
                              input logic [6:0][1:0] sw, input logic [2:0][2:0] mw);
    vec_t e;
    e.name = nm; e.rst = rst;
    e.addr[0] = a0; e.addr[1] = a1; e.addr[2] = a2;
    e.awv = awv; e.awr = awr; e.wv = wv; e.wl = wl; e.bv = bv;
    e.sw = sw; e.mw = mw;
    vecs.push_back(e);
  endfunction

  task automatic cycle();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    ARESET = 1'b0; AWADDR_M = '0; AWVALID_M = '0; WVALID_M = '0; WLAST_M = '0;
    BVALID_S = '0; AWREADY_S = RDY; WREADY_S = RDY; BREADY_M = 3'b111;
  endtask

  task automatic check(input string nm, input logic [6:0][1:0] sw, input logic [2:0][2:0] mw, input logic [6:0] to);
    total++;
    if (SWIdx !== sw || MWIdx !== mw || WTimeout !== to) begin
      bad++;
      $display("FAIL %s: got SWIdx=%h MWIdx=%h WTimeout=%b, want SWIdx=%h MWIdx=%h WTimeout=%b",
               nm, SWIdx, MWIdx, WTimeout, sw, mw, to);
    end else begin
      $display("ok   %s: SWIdx=%h MWIdx=%h WTimeout=%b", nm, SWIdx, MWIdx, WTimeout);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    add("rst0", 1, 32'h0, 32'h0, 32'h0, 3'b111, RDY, 3'b000, 3'b000, 7'h00, SW_IDLE, MW_IDLE);
    add("rst1", 1, 32'h0, 32'h0, 32'h0, 3'b111, RDY, 3'b000, 3'b000, 7'h00, SW_IDLE, MW_IDLE);
    // single write M1 -> S2, 4-beat burst
    add("w_grant", 0, 32'h0, 32'h0002_0010, 32'h0, 3'b010, RDY, 3'b000, 3'b000, 7'h00, swx(2,1), mwx(1,2));
    add("w_aw",    0, 32'h0, 32'h0002_0010, 32'h0, 3'b010, RDY, 3'b000, 3'b000, 7'h00, swx(2,1), mwx(1,2));
    add("w_beat1", 0, 32'h0, 32'h0002_0010, 32'h0, 3'b000, RDY, 3'b010, 3'b000, 7'h00, swx(2,1), mwx(1,2));
    add("w_beat2", 0, 32'h0, 32'h0002_0010, 32'h0, 3'b000, RDY, 3'b010, 3'b000, 7'h00, swx(2,1), mwx(1,2));
    add("w_beat3", 0, 32'h0, 32'h0002_0010, 32'h0, 3'b000, RDY, 3'b010, 3'b000, 7'h00, swx(2,1), mwx(1,2));
    add("w_beat4", 0, 32'h0, 32'h0002_0010, 32'h0, 3'b000, RDY, 3'b010, 3'b010, 7'h00, swx(2,1), mwx(1,2));
    add("w_bwait", 0, 32'h0, 32'h0002_0010, 32'h0, 3'b000, RDY, 3'b000, 3'b000, 7'h00, swx(2,1), mwx(1,2));
    add("w_bresp", 0, 32'h0, 32'h0002_0010, 32'h0, 3'b000, RDY, 3'b000, 3'b000, 7'h04, SW_IDLE, MW_IDLE);
    // contention M0/M1 -> S5, pointer 0
    add("c_grant0", 0, 32'h2000_0000, 32'h2000_0000, 32'h0, 3'b011, RDY, 3'b000, 3'b000, 7'h00, swx(5,0), mwx(0,5));
    add("c_aw0",    0, 32'h2000_0000, 32'h2000_0000, 32'h0, 3'b011, RDY, 3'b000, 3'b000, 7'h00, swx(5,0), mwx(0,5));
    add("c_last0",  0, 32'h2000_0000, 32'h2000_0000, 32'h0, 3'b010, RDY, 3'b001, 3'b001, 7'h00, swx(5,0), mwx(0,5));
    add("c_b0",     0, 32'h2000_0000, 32'h2000_0000, 32'h0, 3'b010, RDY, 3'b000, 3'b000, 7'h20, SW_IDLE, MW_IDLE);
    add("c_grant1", 0, 32'h2000_0000, 32'h2000_0000, 32'h0, 3'b010, RDY, 3'b000, 3'b000, 7'h00, swx(5,1), mwx(1,5));
    add("c_aw1",    0, 32'h2000_0000, 32'h2000_0000, 32'h0, 3'b010, RDY, 3'b000, 3'b000, 7'h00, swx(5,1), mwx(1,5));
    add("c_last1",  0, 32'h2000_0000, 32'h2000_0000, 32'h0, 3'b000, RDY, 3'b010, 3'b010, 7'h00, swx(5,1), mwx(1,5));
    add("c_b1",     0, 32'h2000_0000, 32'h2000_0000, 32'h0, 3'b000, RDY, 3'b000, 3'b000, 7'h20, SW_IDLE, MW_IDLE);
    // round robin: S5 pointer now 2, top of S5 range
    add("rr_grant2", 0, 32'h201F_FFFF, 32'h201F_FFFF, 32'h201F_FFFF, 3'b111, RDY, 3'b000, 3'b000, 7'h00, swx(5,2), mwx(2,5));
    add("rr_aw2",    0, 32'h201F_FFFF, 32'h201F_FFFF, 32'h201F_FFFF, 3'b111, RDY, 3'b000, 3'b000, 7'h00, swx(5,2), mwx(2,5));
    add("rr_last2",  0, 32'h201F_FFFF, 32'h201F_FFFF, 32'h201F_FFFF, 3'b011, RDY, 3'b100, 3'b100, 7'h00, swx(5,2), mwx(2,5));
    add("rr_b2",     0, 32'h201F_FFFF, 32'h201F_FFFF, 32'h201F_FFFF, 3'b011, RDY, 3'b000, 3'b000, 7'h20, SW_IDLE, MW_IDLE);
    add("rr_grant0", 0, 32'h201F_FFFF, 32'h201F_FFFF, 32'h201F_FFFF, 3'b011, RDY, 3'b000, 3'b000, 7'h00, swx(5,0), mwx(0,5));
    add("rr_aw0",    0, 32'h201F_FFFF, 32'h201F_FFFF, 32'h201F_FFFF, 3'b011, RDY, 3'b000, 3'b000, 7'h00, swx(5,0), mwx(0,5));
    add("rr_last0",  0, 32'h201F_FFFF, 32'h201F_FFFF, 32'h201F_FFFF, 3'b000, RDY, 3'b001, 3'b001, 7'h00, swx(5,0), mwx(0,5));
    add("rr_b0",     0, 32'h201F_FFFF, 32'h201F_FFFF, 32'h201F_FFFF, 3'b000, RDY, 3'b000, 3'b000, 7'h20, SW_IDLE, MW_IDLE);
    // parallel grants, busy-master exclusion, S3 upper bound inclusive
    add("p_grant",  0, 32'h0001_0000, 32'h1001_0004, 32'h0, 3'b011, RDY, 3'b000, 3'b000, 7'h00, swx(1,0,4,1), mwx(0,1,1,4));
    add("p_aw",     0, 32'h0001_0000, 32'h1001_0004, 32'h0, 3'b011, RDY, 3'b000, 3'b000, 7'h00, swx(1,0,4,1), mwx(0,1,1,4));
    add("p_busy",   0, 32'h1002_0400, 32'h1001_0004, 32'h0, 3'b001, RDY, 3'b010, 3'b010, 7'h00, swx(1,0,4,1), mwx(0,1,1,4));
    add("p_mix",    0, 32'h1002_0400, 32'h1001_0004, 32'h0, 3'b001, RDY, 3'b001, 3'b001, 7'h10, swx(1,0), mwx(0,1));
    add("p_rel",    0, 32'h1002_0400, 32'h1001_0004, 32'h0, 3'b001, RDY, 3'b000, 3'b000, 7'h02, SW_IDLE, MW_IDLE);
    add("p_s3",     0, 32'h1002_0400, 32'h1001_0004, 32'h0, 3'b001, RDY, 3'b000, 3'b000, 7'h00, swx(3,0), mwx(0,3));
    add("p_s3aw",   0, 32'h1002_0400, 32'h1001_0004, 32'h0, 3'b001, RDY, 3'b000, 3'b000, 7'h00, swx(3,0), mwx(0,3));
    add("p_s3last", 0, 32'h1002_0400, 32'h1001_0004, 32'h0, 3'b000, RDY, 3'b001, 3'b001, 7'h00, swx(3,0), mwx(0,3));
    add("p_s3b",    0, 32'h1002_0400, 32'h1001_0004, 32'h0, 3'b000, RDY, 3'b000, 3'b000, 7'h08, SW_IDLE, MW_IDLE);
    // decode miss to S6 with AWREADY stall; WLAST during AW must be ignored
    add("d_grant",   0, 32'h0, 32'h0, 32'h3000_0000, 3'b100, RDY,   3'b000, 3'b000, 7'h00, swx(6,2), mwx(2,6));
    add("d_awstall", 0, 32'h0, 32'h0, 32'h3000_0000, 3'b100, 7'h00, 3'b100, 3'b100, 7'h00, swx(6,2), mwx(2,6));
    add("d_aw",      0, 32'h0, 32'h0, 32'h3000_0000, 3'b100, RDY,   3'b100, 3'b100, 7'h00, swx(6,2), mwx(2,6));
    add("d_data",    0, 32'h0, 32'h0, 32'h3000_0000, 3'b000, RDY,   3'b000, 3'b000, 7'h40, swx(6,2), mwx(2,6));
    add("d_last",    0, 32'h0, 32'h0, 32'h3000_0000, 3'b000, RDY,   3'b100, 3'b100, 7'h00, swx(6,2), mwx(2,6));
    add("d_b",       0, 32'h0, 32'h0, 32'h3000_0000, 3'b000, RDY,   3'b000, 3'b000, 7'h40, SW_IDLE, MW_IDLE);
    // just past the S0 and S3 ranges
    add("e_rom_hi", 0, 32'h0000_4000, 32'h0, 32'h0, 3'b001, RDY, 3'b000, 3'b000, 7'h00, swx(6,0), mwx(0,6));
    add("e_rom_aw", 0, 32'h0000_4000, 32'h0, 32'h0, 3'b001, RDY, 3'b000, 3'b000, 7'h00, swx(6,0), mwx(0,6));
    add("e_rom_wl", 0, 32'h0000_4000, 32'h0, 32'h0, 3'b000, RDY, 3'b001, 3'b001, 7'h00, swx(6,0), mwx(0,6));
    add("e_rom_b",  0, 32'h0000_4000, 32'h0, 32'h0, 3'b000, RDY, 3'b000, 3'b000, 7'h40, SW_IDLE, MW_IDLE);
    add("e_dma_hi", 0, 32'h0, 32'h1002_0401, 32'h0, 3'b010, RDY, 3'b000, 3'b000, 7'h00, swx(6,1), mwx(1,6));
    add("e_dma_aw", 0, 32'h0, 32'h1002_0401, 32'h0, 3'b010, RDY, 3'b000, 3'b000, 7'h00, swx(6,1), mwx(1,6));
    add("e_dma_wl", 0, 32'h0, 32'h1002_0401, 32'h0, 3'b000, RDY, 3'b010, 3'b010, 7'h00, swx(6,1), mwx(1,6));
    add("e_dma_b",  0, 32'h0, 32'h1002_0401, 32'h0, 3'b000, RDY, 3'b000, 3'b000, 7'h40, SW_IDLE, MW_IDLE);
    // reset returns the S0 pointer to 0 (without it M1 would win)
    add("f_grant",   0, 32'h0000_3FFF, 32'h0000_3FFF, 32'h0, 3'b011, RDY, 3'b000, 3'b000, 7'h00, swx(0,0), mwx(0,0));
    add("f_aw",      0, 32'h0000_3FFF, 32'h0000_3FFF, 32'h0, 3'b011, RDY, 3'b000, 3'b000, 7'h00, swx(0,0), mwx(0,0));
    add("f_last",    0, 32'h0000_3FFF, 32'h0000_3FFF, 32'h0, 3'b010, RDY, 3'b001, 3'b001, 7'h00, swx(0,0), mwx(0,0));
    add("f_b",       0, 32'h0000_3FFF, 32'h0000_3FFF, 32'h0, 3'b010, RDY, 3'b000, 3'b000, 7'h01, SW_IDLE, MW_IDLE);
    add("f_rst",     1, 32'h0000_3FFF, 32'h0000_3FFF, 32'h0, 3'b011, RDY, 3'b000, 3'b000, 7'h00, SW_IDLE, MW_IDLE);
    add("f_regrant", 0, 32'h0000_3FFF, 32'h0000_3FFF, 32'h0, 3'b011, RDY, 3'b000, 3'b000, 7'h00, swx(0,0), mwx(0,0));
    add("f_aw2",     0, 32'h0000_3FFF, 32'h0000_3FFF, 32'h0, 3'b011, RDY, 3'b000, 3'b000, 7'h00, swx(0,0), mwx(0,0));
    add("f_last2",   0, 32'h0000_3FFF, 32'h0000_3FFF, 32'h0, 3'b000, RDY, 3'b001, 3'b001, 7'h00, swx(0,0), mwx(0,0));
    add("f_b2",      0, 32'h0000_3FFF, 32'h0000_3FFF, 32'h0, 3'b000, RDY, 3'b000, 3'b000, 7'h01, SW_IDLE, MW_IDLE);

    idle_inputs();
    for (int i = 0; i < vecs.size(); i++) begin
      ARESET    = vecs[i].rst;
      AWADDR_M  = vecs[i].addr;
      AWVALID_M = vecs[i].awv;
      AWREADY_S = vecs[i].awr;
      WVALID_M  = vecs[i].wv;
      WLAST_M   = vecs[i].wl;
      BVALID_S  = vecs[i].bv;
      cycle();
      check(vecs[i].name, vecs[i].sw, vecs[i].mw, 7'h00);
    end

    // reset in the middle of a W burst aborts the transaction
    idle_inputs();
    AWADDR_M[2] = 32'h0000_0100; AWVALID_M = 3'b100;
    cycle(); check("abort_grant", swx(0,2), mwx(2,0), 7'h00);
    cycle(); check("abort_aw", swx(0,2), mwx(2,0), 7'h00);
    AWVALID_M = 3'b000; WVALID_M = 3'b100;
    cycle(); check("abort_beat", swx(0,2), mwx(2,0), 7'h00);
    ARESET = 1'b1;
    cycle(); check("abort_rst", SW_IDLE, MW_IDLE, 7'h00);
    ARESET = 1'b0; WLAST_M = 3'b100; BVALID_S = 7'h01;
    cycle(); check("abort_after", SW_IDLE, MW_IDLE, 7'h00);

    // B withheld after WLAST
    idle_inputs();
    AWADDR_M[1] = 32'h0002_0010; AWVALID_M = 3'b010;
    cycle(); check("to_grant", swx(2,1), mwx(1,2), 7'h00);
    cycle(); check("to_aw", swx(2,1), mwx(1,2), 7'h00);
    AWVALID_M = 3'b000; WVALID_M = 3'b010; WLAST_M = 3'b010;
    cycle(); check("to_resp", swx(2,1), mwx(1,2), 7'h00);
    WVALID_M = 3'b000; WLAST_M = 3'b000;
`ifdef WARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      cycle(); check($sformatf("to_wait%0d", k), swx(2,1), mwx(1,2), 7'h00);
    end
    cycle(); check("to_fire", SW_IDLE, MW_IDLE, 7'h04);
    cycle(); check("to_clear", SW_IDLE, MW_IDLE, 7'h00);
`else
    for (int k = 1; k <= 12; k++) begin
      cycle(); check($sformatf("to_hold%0d", k), swx(2,1), mwx(1,2), 7'h00);
    end
    BVALID_S = 7'h04;
    cycle(); check("to_bresp", SW_IDLE, MW_IDLE, 7'h00);
    BVALID_S = 7'h00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
